// File: rtl/ahb_master_if.sv
// ahb_master_if
// Bundles the AHB-Lite initiator signals and the command/response handshake
// of ahb_master.
//   master modport : the ahb_master side (drives HTRANS/HADDR/HWRITE/HSIZE/
//                    HWDATA, cmd_ready, rsp_*; samples HREADY/HRESP/HRDATA,
//                    cmd_*).
//   slave modport  : the environment side (AHB slave plus command source).
//
// Handshake semantics: a command transfers at a rising HCLK edge where
// cmd_valid and cmd_ready are both 1. While cmd_valid is 1 and cmd_ready is
// 0 the source holds cmd_* stable. rsp_valid is a one-cycle pulse with no
// back-pressure.
interface ahb_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // AHB-Lite bus
  logic [1:0]        HTRANS;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HRESP;
  logic [DATA_W-1:0] HRDATA;

  // Command / response
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
    input  HREADY, HRESP, HRDATA,
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
    output HREADY, HRESP, HRDATA,
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ahb_master.sv
// ahb_master
// Single-initiator AHB-Lite master with a two-stage pipeline: an address
// phase stage (AP) drives HTRANS/HADDR/HWRITE/HSIZE, a data phase stage (DP)
// drives HWDATA and collects HRDATA/HRESP. Each completed data phase yields
// a one-cycle rsp_valid pulse, in command order. A two-cycle ERROR response
// parks the command sitting in AP in a retry register and re-issues it once
// the error has been reported.
// Ports:
//   HCLK       : bus clock, all state on rising edge
//   HRSTN      : asynchronous active-low reset
//   bus        : ahb_master_if.master (AHB-Lite bus + cmd/rsp handshake)
//   dbg_state  : FSM state (0=RUN, 1=ERR1, 2=ERR2)
module ahb_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic         HCLK,
  input  logic         HRSTN,
  ahb_master_if.master bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  state_e            state_q, state_d;

  // Address phase stage
  logic              ap_valid_q, ap_valid_d;
  logic              ap_write_q, ap_write_d;
  logic [ADDR_W-1:0] ap_addr_q,  ap_addr_d;
  logic [2:0]        ap_size_q,  ap_size_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;

  // Data phase stage
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [ADDR_W-1:0] dp_addr_q,  dp_addr_d;
  logic [2:0]        dp_size_q,  dp_size_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;

  // One-entry retry register for a command displaced by an ERROR
  logic              rt_valid_q, rt_valid_d;
  logic              rt_write_q, rt_write_d;
  logic [ADDR_W-1:0] rt_addr_q,  rt_addr_d;
  logic [2:0]        rt_size_q,  rt_size_d;
  logic [DATA_W-1:0] rt_wdata_q, rt_wdata_d;

  // Response outputs
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              cmd_fire;

  // AP can take a command when it is empty or when its contents advance
  // to DP at this edge; no new work is taken while an error is unwinding.
  assign bus.cmd_ready = (!ap_valid_q || bus.HREADY) && (state_q == ST_RUN);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

  // AP fields are never cleared with ap_valid, so an IDLE cycle keeps the
  // previous address/control on the bus.
  assign bus.HTRANS    = ap_valid_q ? 2'b10 : 2'b00;
  assign bus.HADDR     = ap_addr_q;
  assign bus.HWRITE    = ap_write_q;
  assign bus.HSIZE     = ap_size_q;
  assign bus.HWDATA    = dp_wdata_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state_q;

  always_comb begin
    state_d     = state_q;
    ap_valid_d  = ap_valid_q;
    ap_write_d  = ap_write_q;
    ap_addr_d   = ap_addr_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_addr_d   = dp_addr_q;
    dp_size_d   = dp_size_q;
    dp_wdata_d  = dp_wdata_q;
    rt_valid_d  = rt_valid_q;
    rt_write_d  = rt_write_q;
    rt_addr_d   = rt_addr_q;
    rt_size_d   = rt_size_q;
    rt_wdata_d  = rt_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.HREADY) begin
          // DP completes (OKAY, or single-cycle ERROR reported directly).
          if (dp_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = bus.HRESP;
            rsp_rdata_d = (bus.HRESP || dp_write_q) ? '0 : bus.HRDATA;
          end
          dp_valid_d = ap_valid_q;
          if (ap_valid_q) begin
            dp_write_d = ap_write_q;
            dp_addr_d  = ap_addr_q;
            dp_size_d  = ap_size_q;
            dp_wdata_d = ap_wdata_q;
          end
          ap_valid_d = cmd_fire;
          if (cmd_fire) begin
            ap_write_d = bus.cmd_write;
            ap_addr_d  = bus.cmd_addr;
            ap_size_d  = bus.cmd_size;
            ap_wdata_d = bus.cmd_wdata;
          end
        end else if (dp_valid_q && bus.HRESP) begin
          // First ERROR cycle: pull the pending address phase off the bus.
          // A command accepted at this same edge (AP was empty) is parked
          // too, so HTRANS stays IDLE during the second error cycle.
          state_d    = ST_ERR1;
          ap_valid_d = 1'b0;
          if (ap_valid_q) begin
            rt_valid_d = 1'b1;
            rt_write_d = ap_write_q;
            rt_addr_d  = ap_addr_q;
            rt_size_d  = ap_size_q;
            rt_wdata_d = ap_wdata_q;
          end else if (cmd_fire) begin
            rt_valid_d = 1'b1;
            rt_write_d = bus.cmd_write;
            rt_addr_d  = bus.cmd_addr;
            rt_size_d  = bus.cmd_size;
            rt_wdata_d = bus.cmd_wdata;
          end
        end else if (cmd_fire) begin
          // Wait state with an empty AP: the new command can still start.
          ap_valid_d = 1'b1;
          ap_write_d = bus.cmd_write;
          ap_addr_d  = bus.cmd_addr;
          ap_size_d  = bus.cmd_size;
          ap_wdata_d = bus.cmd_wdata;
        end
      end

      ST_ERR1: begin
        // The second error cycle ends on HREADY; the transfer is reported
        // as an error regardless of HRESP at that edge.
        if (bus.HREADY) begin
          state_d     = ST_ERR2;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          dp_valid_d  = 1'b0;
        end
      end

      ST_ERR2: begin
        state_d    = ST_RUN;
        ap_valid_d = rt_valid_q;
        rt_valid_d = 1'b0;
        if (rt_valid_q) begin
          ap_write_d = rt_write_q;
          ap_addr_d  = rt_addr_q;
          ap_size_d  = rt_size_q;
          ap_wdata_d = rt_wdata_q;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRSTN) begin
    if (!HRSTN) begin
      state_q     <= ST_RUN;
      ap_valid_q  <= 1'b0;
      ap_write_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_size_q   <= '0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= '0;
      dp_size_q   <= '0;
      dp_wdata_q  <= '0;
      rt_valid_q  <= 1'b0;
      rt_write_q  <= 1'b0;
      rt_addr_q   <= '0;
      rt_size_q   <= '0;
      rt_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ap_valid_q  <= ap_valid_d;
      ap_write_q  <= ap_write_d;
      ap_addr_q   <= ap_addr_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      dp_size_q   <= dp_size_d;
      dp_wdata_q  <= dp_wdata_d;
      rt_valid_q  <= rt_valid_d;
      rt_write_q  <= rt_write_d;
      rt_addr_q   <= rt_addr_d;
      rt_size_q   <= rt_size_d;
      rt_wdata_q  <= rt_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule
